// File: rtl/o_ddr_serializer.sv
// o_ddr_serializer: parallel-to-DDR gearbox with one-word holding buffer feeding an O_DDR primitive.
// Optional gap detection (GAP pulse, saturating GAP_CNT) is built when O_DDR_SERIALIZER_GAP_DETECT_EN is defined.
module o_ddr_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [1:0]       Q,
    output logic             QV
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
    ,
    output logic             GAP,
    output logic [7:0]       GAP_CNT
`endif
);

    localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

    if (WIDTH < 4 || WIDTH > 16 || WIDTH % 2 != 0) begin : g_bad_width
        $error("o_ddr_serializer: WIDTH must be even and within 4..16");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active, last, load, gap_ev;
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
    logic             gap_q, gap_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
`endif

    assign active = state_q == SHIFT;
    assign last   = active && cnt_q == CW'(WIDTH / 2 - 1);
    assign load   = hold_full_q && (!active || last);
    assign gap_ev = last && !hold_full_q;
    assign DR     = !hold_full_q && E && !R;
    assign Q      = sh_q[1:0];
    assign QV     = active;
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
    assign GAP     = gap_q;
    assign GAP_CNT = gap_cnt_q;
`endif

    // Next state: load beats drain beats shift; accepts only land in an empty holding buffer.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
`endif
        if (E) begin
            if (load) begin
                sh_d        = hold_q;
                cnt_d       = '0;
                state_d     = SHIFT;
                hold_full_d = 1'b0;
            end else if (last) begin
                sh_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else if (active) begin
                sh_d  = sh_q >> 2;
                cnt_d = cnt_q + CW'(1);
            end
            if (DV && DR) begin
                hold_d      = D;
                hold_full_d = 1'b1;
            end
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
            gap_d     = gap_ev;
            gap_cnt_d = (gap_ev && gap_cnt_q != 8'hFF) ? gap_cnt_q + 8'd1 : gap_cnt_q;
`endif
        end
    end

    // State registers; reset discards both the partial and the held word.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
            gap_q       <= 1'b0;
            gap_cnt_q   <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_o_ddr_serializer.sv
// tb_o_ddr_serializer: table-driven directed bench for o_ddr_serializer (WIDTH=8).
module tb_o_ddr_serializer;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       E = 1'b1;
    logic [7:0] D = 8'h00;
    logic       DV = 1'b0;
    logic       DR;
    logic [1:0] Q;
    logic       QV;
    logic       GAP;
    logic [7:0] GAP_CNT;

    int n_chk = 0;
    int n_fail = 0;

    o_ddr_serializer #(.WIDTH(8)) dut (
        .C(C), .R(R), .E(E), .D(D), .DV(DV), .DR(DR), .Q(Q), .QV(QV)
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
        , .GAP(GAP), .GAP_CNT(GAP_CNT)
`endif
    );

`ifndef O_DDR_SERIALIZER_GAP_DETECT_EN
    assign GAP = 1'b0;
    assign GAP_CNT = 8'h00;
`endif

    always #5 C = ~C;

    typedef struct {
        logic       e;
        logic       dv;
        logic [7:0] d;
        logic       dr;
        logic [1:0] q;
        logic       qv;
        logic       gap;
        logic [7:0] gcnt;
    } vec_t;

    vec_t tv[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic dv, input logic [7:0] d, input logic dr,
                                input logic [1:0] q, input logic qv, input logic gap, input logic [7:0] gcnt);
        vec_t v;
        v.e = e; v.dv = dv; v.d = d; v.dr = dr; v.q = q; v.qv = qv; v.gap = gap; v.gcnt = gcnt;
        return v;
    endfunction

    initial begin
        // single word B4: pairs 00,01,11,10 then drain
        tv[0]  = mk(1, 1, 8'hB4, 1, 2'b00, 0, 0, 0);
        tv[1]  = mk(1, 0, 8'h00, 0, 2'b00, 1, 0, 0);
        tv[2]  = mk(1, 0, 8'h00, 1, 2'b01, 1, 0, 0);
        tv[3]  = mk(1, 0, 8'h00, 1, 2'b11, 1, 0, 0);
        tv[4]  = mk(1, 0, 8'h00, 1, 2'b10, 1, 0, 0);
        tv[5]  = mk(1, 0, 8'h00, 1, 2'b00, 0, 1, 1);
        tv[6]  = mk(1, 0, 8'h00, 1, 2'b00, 0, 0, 1);
        // back-to-back 1B, E4: 11,10,01,00,00,01,10,11 with no gap between
        tv[7]  = mk(1, 1, 8'h1B, 1, 2'b00, 0, 0, 1);
        tv[8]  = mk(1, 1, 8'hE4, 0, 2'b11, 1, 0, 1);
        tv[9]  = mk(1, 1, 8'hE4, 1, 2'b10, 1, 0, 1);
        tv[10] = mk(1, 0, 8'h00, 0, 2'b01, 1, 0, 1);
        tv[11] = mk(1, 0, 8'h00, 0, 2'b00, 1, 0, 1);
        tv[12] = mk(1, 0, 8'h00, 0, 2'b00, 1, 0, 1);
        tv[13] = mk(1, 0, 8'h00, 1, 2'b01, 1, 0, 1);
        tv[14] = mk(1, 0, 8'h00, 1, 2'b10, 1, 0, 1);
        tv[15] = mk(1, 0, 8'h00, 1, 2'b11, 1, 0, 1);
        tv[16] = mk(1, 0, 8'h00, 1, 2'b00, 0, 1, 2);
        tv[17] = mk(1, 0, 8'h00, 1, 2'b00, 0, 0, 2);
        // B4 with E low for 3 cycles after the second pair
        tv[18] = mk(1, 1, 8'hB4, 1, 2'b00, 0, 0, 2);
        tv[19] = mk(1, 0, 8'h00, 0, 2'b00, 1, 0, 2);
        tv[20] = mk(1, 0, 8'h00, 1, 2'b01, 1, 0, 2);
        tv[21] = mk(0, 1, 8'h55, 0, 2'b01, 1, 0, 2);
        tv[22] = mk(0, 1, 8'h55, 0, 2'b01, 1, 0, 2);
        tv[23] = mk(0, 1, 8'h55, 0, 2'b01, 1, 0, 2);
        tv[24] = mk(1, 0, 8'h00, 1, 2'b11, 1, 0, 2);
        tv[25] = mk(1, 0, 8'h00, 1, 2'b10, 1, 0, 2);
        tv[26] = mk(1, 0, 8'h00, 1, 2'b00, 0, 1, 3);
        tv[27] = mk(1, 0, 8'h00, 1, 2'b00, 0, 0, 3);

        // reset state
        #2;
        check("rst_q", 32'(Q), 0);
        check("rst_qv", 32'(QV), 0);
        check("rst_dr", 32'(DR), 0);
        check("rst_gcnt", 32'(GAP_CNT), 0);
        step();
        R = 1'b0;
        #1;
        check("rel_dr", 32'(DR), 1);

        for (int i = 0; i < 28; i++) begin
            E = tv[i].e; DV = tv[i].dv; D = tv[i].d;
            #1;
            check($sformatf("v%0d_dr", i), 32'(DR), 32'(tv[i].dr));
            step();
            check($sformatf("v%0d_q", i), 32'(Q), 32'(tv[i].q));
            check($sformatf("v%0d_qv", i), 32'(QV), 32'(tv[i].qv));
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
            check($sformatf("v%0d_gap", i), 32'(GAP), 32'(tv[i].gap));
            check($sformatf("v%0d_gcnt", i), 32'(GAP_CNT), 32'(tv[i].gcnt));
`endif
        end

        // reset mid-stream: 1B loaded, E4 held, two pairs out
        E = 1; DV = 1; D = 8'h1B;
        step();
        D = 8'hE4;
        step();
        check("mr_p1", 32'(Q), 2'b11);
        step();
        check("mr_p2", 32'(Q), 2'b10);
        DV = 0;
        R = 1'b1;
        #1;
        check("mr_q", 32'(Q), 0);
        check("mr_qv", 32'(QV), 0);
        check("mr_dr", 32'(DR), 0);
        check("mr_gcnt", 32'(GAP_CNT), 0);
        step();
        R = 1'b0;
        #1;
        check("mr_rel_dr", 32'(DR), 1);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("mr_idle%0d_qv", i), 32'(QV), 0);
            check($sformatf("mr_idle%0d_q", i), 32'(Q), 0);
        end
        check("mr_gcnt_end", 32'(GAP_CNT), 0);

        // 300 isolated words: every one drains, GAP_CNT tracks then saturates
        for (int w = 1; w <= 300; w++) begin
            DV = 1; D = 8'(w * 37 + 5);
            step();
            DV = 0;
            step();
            check($sformatf("iso%0d_p0", w), 32'(Q), 32'(D[1:0]));
            repeat (4) step();
            check($sformatf("iso%0d_qv", w), 32'(QV), 0);
`ifdef O_DDR_SERIALIZER_GAP_DETECT_EN
            if (w == 254 || w == 255 || w == 256 || w == 300)
                check($sformatf("iso%0d_gcnt", w), 32'(GAP_CNT), (w > 255) ? 32'hFF : 32'(w));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/o_ddr_serializer.md
# o_ddr_serializer

Parallel-to-DDR output gearbox that sits directly upstream of the O_DDR output primitive. It accepts WIDTH-bit words over a valid/ready handshake and emits them LSB-first as one 2-bit pair per clock on Q. Q drives O_DDR.D: Q[0] leaves the pin in the clock-high phase and Q[1] in the clock-low phase. A one-word holding buffer in front of the shift register gives gapless back-to-back streaming.

## Interface
Parameters:
- WIDTH, default 8: parallel word width. Must be even, 4..16; a value outside this range is an elaboration error.

Ports:
- C  in  1: clock, shared with the downstream O_DDR.C.
- R  in  1: reset, asynchronous, active-high. Clears all state.
- E  in  1: enable. When low, all state is frozen.
- D  in  WIDTH: parallel word.
- DV  in  1: D valid.
- DR  out  1: ready. A word transfers on a posedge where DV && DR && E.
- Q  out  2: DDR pair to O_DDR.D. Registered.
- QV  out  1: Q carries word data. Low during idle fill.
- GAP  out  1: one-cycle pulse when the stream runs dry. Present only with the macro.
- GAP_CNT  out  8: saturating gap count. Present only with the macro.

## Operation
- State: hold[WIDTH-1:0], hold_full, sh[WIDTH-1:0], cnt (0..WIDTH/2-1), active. QV = active; Q = sh[1:0].
- DR = !hold_full && E && !R. This output is combinational.
- Let last = active && cnt == WIDTH/2-1.
- Let load = hold_full && (!active || last).
- Each posedge with E=1, in priority order:
  - load: sh <= hold, cnt <= 0, active <= 1, hold_full <= 0.
  - else last (hold empty): sh <= 0, cnt <= 0, active <= 0. This is the gap event.
  - else active: sh <= sh >> 2, cnt <= cnt+1.
  - accept (DV && DR): hold <= D, hold_full <= 1. Accept and load cannot coincide because DR requires hold empty.
- States: IDLE (active=0), SHIFT (active=1).
  - IDLE -> SHIFT on load.
  - SHIFT -> SHIFT on load at last.
  - SHIFT -> IDLE on last with hold empty.
- Idle fill: Q=2'b00, QV=0.
- E=0: no register changes, DR=0, Q and QV hold their values.
- R asserted at any time, including mid-word: immediately Q=0, QV=0, DR=0, hold_full=0, cnt=0, GAP=0, GAP_CNT=0. The partial word and the held word are discarded.

## Timing
- Reset values: Q=2'b00, QV=0, DR=0 while R is high, GAP=0, GAP_CNT=0. DR=1 in the first cycle after R falls (E=1).
- Latency from an idle pipeline, for a word accepted at edge k:
  - hold_full after edge k.
  - Q=D[1:0], QV=1 after edge k+1.
  - Q=D[2i+1:2i] after edge k+1+i.
  - Final pair after edge k+WIDTH/2.
  - QV=0 after edge k+WIDTH/2+1 if no successor word.
- Throughput: one word per WIDTH/2 cycles with no idle pair, provided DV is high whenever DR is high. WIDTH>=4 guarantees that the holding buffer refills before the next load.
- DR falls the cycle after accept and rises the cycle after load.
- Pin-level: O_DDR samples Q at posedge. Bit 2i appears one posedge later in the high phase; bit 2i+1 appears in the following low phase.

## Configuration
- Macro O_DDR_SERIALIZER_GAP_DETECT_EN.
- Defined:
  - GAP is registered and pulses high for exactly one cycle after each SHIFT->IDLE transition, i.e. coincident with QV falling.
  - GAP_CNT increments on each such event and saturates at 8'hFF.
  - Both are cleared only by R.
  - E=0 freezes both.
- Undefined: GAP and GAP_CNT ports and their logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8 and E=1 unless stated.
- Reset: R=1 mid-stream -> Q=00, QV=0, DR=0 immediately. After R falls -> DR=1 next cycle, GAP_CNT=0.
- Single word 8'hB4 accepted at edge k:
  - Q=00, 01, 11, 10 after edges k+1..k+4, with QV=1 for these 4 cycles.
  - After k+5: Q=00, QV=0, GAP=1 for one cycle, GAP_CNT=1.
- Back-to-back 8'h1B then 8'hE4 with DV held high:
  - QV high for 8 consecutive cycles with pairs 11,10,01,00,00,01,10,11.
  - No GAP between the words. GAP_CNT=1 after the stream ends.
- E=0 for 3 cycles after the second pair of 8'hB4 -> Q=01 and QV=1 frozen, DR=0. After E returns -> 11, 10, then idle.
- R pulse after 2 pairs of 8'h1B with 8'hE4 held -> Q=00, QV=0, DR=1 after release. 8'hE4 is not emitted. GAP_CNT=0.
- 300 isolated single words, each followed by idle (macro on) -> GAP_CNT saturates at 8'hFF and stays there. Macro off -> build has no GAP ports.
